hsid_sq_df_sched: RTL and testbench
===================================

// Module: hsid_sq_df_sched
// PURPOSE
//  Sequencer for the squared-difference accumulator (sq_df_acc). On start it streams one pixel
//  vector against every reference vector of the HSI library, band by band, into sq_df_acc.
//  It collects one final distance per reference and reports the minimum distance and the index
//  of the winning reference. Sits between pixel/library buffers and sq_df_acc in the HSID core.
// PARAMETERS
//  DATA_WIDTH        HSID_DATA_WIDTH (16)     band sample width
//  DATA_WIDTH_ACC    HSID_DATA_WIDTH_ACC      accumulator/distance width
//  VECTOR_LENGTH     HSID_VECTOR_LENGTH       max bands per vector; BAND_W = $clog2(VECTOR_LENGTH+1)
//  HSI_LIBRARY_SIZE  HSID_HSI_LIBRARY_SIZE    max references; REF_W = $clog2(HSI_LIBRARY_SIZE)
// PORTS
//  clk            in   1               clock
//  rst            in   1               asynchronous reset, active high
//  start          in   1               begin classification; sampled only in IDLE
//  cfg_vlen       in   BAND_W          bands per vector, latched on accepted start
//  cfg_lib_size   in   REF_W+1         references to scan, latched on accepted start
//  busy           out  1               high from accepted start until done
//  done           out  1               one-cycle pulse, result valid
//  error          out  1               valid with done: bad config or ref mismatch
//  min_value      out  DATA_WIDTH_ACC  smallest distance; held until next start
//  min_ref        out  REF_W           index of smallest distance; held until next start
//  mem_rd_en      out  1               read strobe to pixel and library buffers
//  mem_rd_band    out  BAND_W          band index to read
//  mem_rd_ref     out  REF_W           library reference index to read
//  px_rd_data     in   DATA_WIDTH      pixel sample, valid 1 cycle after mem_rd_en
//  lib_rd_data    in   DATA_WIDTH      library sample, valid 1 cycle after mem_rd_en
//  acc_init_en    out  1               to sq_df_acc initial_acc_en
//  acc_init       out  DATA_WIDTH_ACC  to sq_df_acc initial_acc; always 0
//  acc_in_valid   out  1               to sq_df_acc data_in_valid
//  acc_in_a/b     out  DATA_WIDTH      to data_in_a (pixel) and data_in_b (library)
//  acc_in_ref     out  REF_W           to data_in_ref
//  acc_in_last    out  1               to data_in_last
//  acc_valid      in   1               from sq_df_acc
//  acc_value      in   DATA_WIDTH_ACC  from sq_df_acc
//  acc_last       in   1               from sq_df_acc; final distance of one reference
//  acc_ref        in   REF_W           from sq_df_acc
// BEHAVIOUR
//  - Reset: state IDLE. All outputs 0, except min_value = all ones.
//  - States: IDLE -> FEED on start. FEED -> DRAIN after the last read. DRAIN -> DONE when results == lib_size.
//    DONE -> IDLE after 1 cycle. Bad config goes IDLE -> DONE directly.
//  - Bad config: cfg_vlen==0, cfg_vlen>VECTOR_LENGTH, cfg_lib_size==0 or >HSI_LIBRARY_SIZE.
//    Response: no reads, done and error pulse 2 cycles after start, min_value all ones, min_ref 0.
//  - FEED: one mem_rd_en per cycle, no bubbles. Band advances 0..vlen-1, then wraps to 0 with ref+1.
//    Total reads = vlen*lib_size.
//  - Read data is registered into acc_in_* 1 cycle after mem_rd_en. acc_in_valid mirrors the delayed strobe.
//  - With the first band of each ref, acc_init_en=1. With band vlen-1, acc_in_last=1.
//    acc_in_ref = ref being fed.
//  - Results: on each acc_valid&&acc_last, increment the result count.
//    If acc_value < running min (strict; ties keep the lower index), update min_value/min_ref.
//    Running min is reset to all ones on start.
//  - acc_ref must equal the result count at each last result. Otherwise set sticky error; the scan still completes.
//  - acc_valid without acc_last is ignored. Results are accepted in FEED and DRAIN.
//  - done asserts the cycle after the final result. busy falls in the same cycle.
//    A start in the done cycle is ignored.
//  - Start in any state other than IDLE is ignored. Config changes mid-scan have no effect.
//  - Reset mid-scan: immediate return to IDLE, all strobes low. In-flight accumulator results are discarded.
// TESTING
//  1. vlen=4, lib=3, px={1,2,3,4}, lib0={1,2,3,4}, lib1={2,2,2,2}, lib2={0,0,0,0}.
//     Expect distances 0/6/30 -> min_value=0, min_ref=0, error=0, done once.
//  2. vlen=2, lib=3, distances {9,4,4} -> min_value=4, min_ref=1 (tie keeps lower index).
//  3. vlen=3, lib=2: check 6 consecutive mem_rd_en pulses, acc_init_en at bands 0, acc_in_last at band 2,
//     and acc_in_ref 0,0,0,1,1,1.
//  4. cfg_vlen=0 -> no mem_rd_en, done and error 2 cycles after start, min_value all ones.
//  5. Assert rst during FEED of a vlen=8, lib=4 scan -> IDLE next cycle, strobes low.
//     A new start then completes correctly.
//  6. Corrupt acc_ref on the 2nd result -> error=1 at done; min is still computed over all results.
//     start pulsed while busy is ignored.

Source files
------------

// File: rtl/hsid_sq_df_sched.sv
// Scan sequencer for sq_df_acc: streams one pixel against every library
// reference, collects per-reference distances and reports the minimum.
module hsid_sq_df_sched #(
   parameter int unsigned DATA_WIDTH       = 16,
   parameter int unsigned DATA_WIDTH_ACC   = 40,
   parameter int unsigned VECTOR_LENGTH    = 16,
   parameter int unsigned HSI_LIBRARY_SIZE = 8,
   localparam int unsigned BAND_W = $clog2(VECTOR_LENGTH + 1),
   localparam int unsigned REF_W  = $clog2(HSI_LIBRARY_SIZE),
   localparam int unsigned LIB_W  = REF_W + 1
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      start,
   input  logic [BAND_W-1:0]         cfg_vlen,
   input  logic [LIB_W-1:0]          cfg_lib_size,
   output logic                      busy,
   output logic                      done,
   output logic                      error,
   output logic [DATA_WIDTH_ACC-1:0] min_value,
   output logic [REF_W-1:0]          min_ref,
   output logic                      mem_rd_en,
   output logic [BAND_W-1:0]         mem_rd_band,
   output logic [REF_W-1:0]          mem_rd_ref,
   input  logic [DATA_WIDTH-1:0]     px_rd_data,
   input  logic [DATA_WIDTH-1:0]     lib_rd_data,
   output logic                      acc_init_en,
   output logic [DATA_WIDTH_ACC-1:0] acc_init,
   output logic                      acc_in_valid,
   output logic [DATA_WIDTH-1:0]     acc_in_a,
   output logic [DATA_WIDTH-1:0]     acc_in_b,
   output logic [REF_W-1:0]          acc_in_ref,
   output logic                      acc_in_last,
   input  logic                      acc_valid,
   input  logic [DATA_WIDTH_ACC-1:0] acc_value,
   input  logic                      acc_last,
   input  logic [REF_W-1:0]          acc_ref
);

   typedef enum logic [1:0] {S_IDLE, S_FEED, S_DRAIN, S_DONE} state_t;

   state_t                    state_q, state_d;
   logic [BAND_W-1:0]         vlen_q, vlen_d;
   logic [LIB_W-1:0]          lib_q, lib_d;
   logic [LIB_W-1:0]          cnt_q, cnt_d;
   logic                      err_q, err_d;
   logic                      bad_q, bad_d;
   logic                      busy_d, done_d, error_d, rd_en_d;
   logic [BAND_W-1:0]         band_d;
   logic [REF_W-1:0]          ref_d;
   logic [DATA_WIDTH_ACC-1:0] min_d;
   logic [REF_W-1:0]          min_ref_d;

   logic                      rd_v1, rd_first1, rd_last1;
   logic [REF_W-1:0]          rd_ref1;

   logic                      cfg_bad_c, start_ok_c, res_c, mism_c;
   logic                      band_end_c, ref_end_c, final_c;
   logic [LIB_W-1:0]          cnt_inc_c;

   // Initial accumulator value is always zero
   assign acc_init = '0;

   // Shared decode of config, read position and incoming results
   always_comb begin
      cfg_bad_c  = (cfg_vlen == '0) || (cfg_vlen > BAND_W'(VECTOR_LENGTH)) ||
                   (cfg_lib_size == '0) || (cfg_lib_size > LIB_W'(HSI_LIBRARY_SIZE));
      start_ok_c = start && (state_q == S_IDLE) && !done;
      res_c      = acc_valid && acc_last && ((state_q == S_FEED) || (state_q == S_DRAIN));
      mism_c     = res_c && ({1'b0, acc_ref} != cnt_q);
      cnt_inc_c  = cnt_q + LIB_W'(1);
      band_end_c = (mem_rd_band == vlen_q - BAND_W'(1));
      ref_end_c  = ({1'b0, mem_rd_ref} == lib_q - LIB_W'(1));
      final_c    = (state_q == S_DRAIN) &&
                   ((res_c && (cnt_inc_c >= lib_q)) || (cnt_q >= lib_q));
   end

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= S_IDLE;
      else     state_q <= state_d;
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (start_ok_c) state_d = cfg_bad_c ? S_DONE : S_FEED;
         S_FEED:  if (band_end_c && ref_end_c) state_d = S_DRAIN;
         S_DRAIN: if (final_c) state_d = S_DONE;
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // Next values of registered outputs, scan counters and result tracking
   always_comb begin
      vlen_d    = vlen_q;
      lib_d     = lib_q;
      cnt_d     = cnt_q;
      err_d     = err_q;
      bad_d     = bad_q;
      busy_d    = busy;
      done_d    = 1'b0;
      error_d   = 1'b0;
      rd_en_d   = mem_rd_en;
      band_d    = mem_rd_band;
      ref_d     = mem_rd_ref;
      min_d     = min_value;
      min_ref_d = min_ref;

      // final distance of one reference: count it, check order, track minimum
      if (res_c) begin
         cnt_d = cnt_inc_c;
         if (mism_c) err_d = 1'b1;
         if (acc_value < min_value) begin
            min_d     = acc_value;
            min_ref_d = cnt_q[REF_W-1:0];
         end
      end

      case (state_q)
         S_IDLE: begin
            if (start_ok_c) begin
               vlen_d    = cfg_vlen;
               lib_d     = cfg_lib_size;
               bad_d     = cfg_bad_c;
               cnt_d     = '0;
               err_d     = 1'b0;
               busy_d    = 1'b1;
               min_d     = '1;
               min_ref_d = '0;
               band_d    = '0;
               ref_d     = '0;
               rd_en_d   = !cfg_bad_c;
            end
         end
         S_FEED: begin
            if (band_end_c) begin
               band_d = '0;
               if (ref_end_c) rd_en_d = 1'b0;
               else           ref_d   = mem_rd_ref + REF_W'(1);
            end else begin
               band_d = mem_rd_band + BAND_W'(1);
            end
         end
         S_DRAIN: begin
            if (final_c) begin
               done_d  = 1'b1;
               error_d = err_q | mism_c;
               busy_d  = 1'b0;
            end
         end
         S_DONE: begin
            // rejected config reports one cycle later than a completed scan
            if (bad_q) begin
               done_d  = 1'b1;
               error_d = 1'b1;
               busy_d  = 1'b0;
            end
         end
         default: ;
      endcase
   end

   // Output and control registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         vlen_q      <= '0;
         lib_q       <= '0;
         cnt_q       <= '0;
         err_q       <= 1'b0;
         bad_q       <= 1'b0;
         busy        <= 1'b0;
         done        <= 1'b0;
         error       <= 1'b0;
         mem_rd_en   <= 1'b0;
         mem_rd_band <= '0;
         mem_rd_ref  <= '0;
         min_value   <= '1;
         min_ref     <= '0;
      end else begin
         vlen_q      <= vlen_d;
         lib_q       <= lib_d;
         cnt_q       <= cnt_d;
         err_q       <= err_d;
         bad_q       <= bad_d;
         busy        <= busy_d;
         done        <= done_d;
         error       <= error_d;
         mem_rd_en   <= rd_en_d;
         mem_rd_band <= band_d;
         mem_rd_ref  <= ref_d;
         min_value   <= min_d;
         min_ref     <= min_ref_d;
      end
   end

   // Delay read tags by the buffer latency, then register data with them
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_v1        <= 1'b0;
         rd_first1    <= 1'b0;
         rd_last1     <= 1'b0;
         rd_ref1      <= '0;
         acc_in_valid <= 1'b0;
         acc_init_en  <= 1'b0;
         acc_in_last  <= 1'b0;
         acc_in_ref   <= '0;
         acc_in_a     <= '0;
         acc_in_b     <= '0;
      end else begin
         rd_v1        <= mem_rd_en;
         rd_first1    <= mem_rd_en && (mem_rd_band == '0);
         rd_last1     <= mem_rd_en && band_end_c;
         rd_ref1      <= mem_rd_ref;
         acc_in_valid <= rd_v1;
         acc_init_en  <= rd_first1;
         acc_in_last  <= rd_last1;
         acc_in_ref   <= rd_ref1;
         if (rd_v1) begin
            acc_in_a <= px_rd_data;
            acc_in_b <= lib_rd_data;
         end
      end
   end

endmodule

// File: tb/tb_hsid_sq_df_sched.sv
// Bench for hsid_sq_df_sched with behavioural buffers and accumulator.
module tb_hsid_sq_df_sched;
   localparam int unsigned DW  = 16;
   localparam int unsigned DWA = 40;
   localparam int unsigned VL  = 8;
   localparam int unsigned LS  = 4;
   localparam int unsigned BW  = 4;
   localparam int unsigned RW  = 2;
   localparam int unsigned LW  = 3;
   localparam longint ONES = (64'd1 << DWA) - 1;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic start = 1'b0;
   logic [BW-1:0] cfg_vlen = '0;
   logic [LW-1:0] cfg_lib_size = '0;
   logic busy, done, error;
   logic [DWA-1:0] min_value;
   logic [RW-1:0] min_ref;
   logic mem_rd_en;
   logic [BW-1:0] mem_rd_band;
   logic [RW-1:0] mem_rd_ref;
   logic [DW-1:0] px_rd_data = '0;
   logic [DW-1:0] lib_rd_data = '0;
   logic acc_init_en;
   logic [DWA-1:0] acc_init;
   logic acc_in_valid;
   logic [DW-1:0] acc_in_a, acc_in_b;
   logic [RW-1:0] acc_in_ref;
   logic acc_in_last;
   logic acc_valid = 1'b0;
   logic [DWA-1:0] acc_value = '0;
   logic acc_last = 1'b0;
   logic [RW-1:0] acc_ref = '0;

   int checks = 0;
   int errors = 0;
   int cyc = 0;

   hsid_sq_df_sched #(.DATA_WIDTH(DW), .DATA_WIDTH_ACC(DWA), .VECTOR_LENGTH(VL),
                      .HSI_LIBRARY_SIZE(LS)) dut (
      .clk(clk), .rst(rst), .start(start), .cfg_vlen(cfg_vlen), .cfg_lib_size(cfg_lib_size),
      .busy(busy), .done(done), .error(error), .min_value(min_value), .min_ref(min_ref),
      .mem_rd_en(mem_rd_en), .mem_rd_band(mem_rd_band), .mem_rd_ref(mem_rd_ref),
      .px_rd_data(px_rd_data), .lib_rd_data(lib_rd_data),
      .acc_init_en(acc_init_en), .acc_init(acc_init), .acc_in_valid(acc_in_valid),
      .acc_in_a(acc_in_a), .acc_in_b(acc_in_b), .acc_in_ref(acc_in_ref),
      .acc_in_last(acc_in_last), .acc_valid(acc_valid), .acc_value(acc_value),
      .acc_last(acc_last), .acc_ref(acc_ref));

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Pixel and library buffers: one-cycle read latency
   logic [DW-1:0] px_mem  [VL];
   logic [DW-1:0] lib_mem [LS][VL];
   always @(posedge clk) begin
      if (mem_rd_en) begin
         px_rd_data  <= px_mem[mem_rd_band[2:0]];
         lib_rd_data <= lib_mem[mem_rd_ref][mem_rd_band[2:0]];
      end
   end

   // Squared-difference accumulator with variable result latency
   typedef struct {longint value; int ref_i; int due;} pend_t;
   pend_t  pend_q[$];
   pend_t  pe;
   longint acc_run;
   longint dd;
   int     mcyc;
   int     corrupt_ref = -1;
   bit     noise_en = 1'b0;
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         pend_q.delete();
         acc_run = 0;
         mcyc = 0;
         acc_valid <= 1'b0;
         acc_last  <= 1'b0;
         acc_value <= '0;
         acc_ref   <= '0;
      end else begin
         mcyc++;
         if (acc_in_valid) begin
            dd = longint'(acc_in_a) - longint'(acc_in_b);
            acc_run = (acc_init_en ? 64'sd0 : acc_run) + dd * dd;
            if (acc_in_last) begin
               pe.value = acc_run;
               pe.ref_i = (int'(acc_in_ref) == corrupt_ref) ? (int'(acc_in_ref) ^ 1) : int'(acc_in_ref);
               pe.due   = mcyc + int'($urandom_range(0, 3));
               pend_q.push_back(pe);
            end
         end
         if (pend_q.size() > 0 && pend_q[0].due <= mcyc) begin
            acc_valid <= 1'b1;
            acc_last  <= 1'b1;
            acc_value <= DWA'(pend_q[0].value);
            acc_ref   <= RW'(pend_q[0].ref_i);
            void'(pend_q.pop_front());
         end else if (noise_en && $urandom_range(0, 3) == 0) begin
            acc_valid <= 1'b1;
            acc_last  <= 1'b0;
            acc_value <= '0;
            acc_ref   <= RW'($urandom_range(0, 3));
         end else begin
            acc_valid <= 1'b0;
            acc_last  <= 1'b0;
         end
      end
   end

   // Observation queues for read strobes, accumulator feed and results
   typedef struct {int r; int b; int c;} rd_t;
   typedef struct {int r; int a; int bb; bit first; bit last;} st_t;
   rd_t rd_q[$];
   st_t st_q[$];
   int  res_cyc_q[$];
   int  done_cnt = 0;
   rd_t mrd;
   st_t mst;
   always @(negedge clk) begin
      if (mem_rd_en) begin
         mrd.r = int'(mem_rd_ref); mrd.b = int'(mem_rd_band); mrd.c = cyc;
         rd_q.push_back(mrd);
      end
      if (acc_in_valid) begin
         mst.r = int'(acc_in_ref); mst.a = int'(acc_in_a); mst.bb = int'(acc_in_b);
         mst.first = acc_init_en; mst.last = acc_in_last;
         st_q.push_back(mst);
      end
      if (acc_valid && acc_last) res_cyc_q.push_back(cyc);
      if (done) done_cnt++;
   end

   task automatic chk(input string nm, input longint act, input longint exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   // Distance rules: sum of squared band differences, strict minimum keeps lower index
   task automatic model(input int vlen, input int lib, input int corrupt,
                        output longint mn, output int mr, output bit er, output bit bad);
      longint d, t;
      bad = (vlen == 0) || (vlen > int'(VL)) || (lib == 0) || (lib > int'(LS));
      mn = ONES; mr = 0; er = 1'b1;
      if (!bad) begin
         for (int r = 0; r < lib; r++) begin
            d = 0;
            for (int b = 0; b < vlen; b++) begin
               t = longint'(px_mem[b]) - longint'(lib_mem[r][b]);
               d += t * t;
            end
            if (d < mn) begin mn = d; mr = r; end
         end
         er = (corrupt >= 0) && (corrupt < lib);
      end
   endtask

   // pattern: 0 full-range random, 1 small random (ties likely), 2/3 fixed scenarios
   task automatic load_data(input int pattern);
      for (int b = 0; b < int'(VL); b++) begin
         px_mem[b] = (pattern == 0) ? DW'($urandom) : DW'($urandom_range(0, 3));
         for (int r = 0; r < int'(LS); r++)
            lib_mem[r][b] = (pattern == 0) ? DW'($urandom) : DW'($urandom_range(0, 3));
      end
      if (pattern == 2) begin
         for (int b = 0; b < 4; b++) begin
            px_mem[b] = DW'(b + 1); lib_mem[0][b] = DW'(b + 1);
            lib_mem[1][b] = DW'(2);  lib_mem[2][b] = DW'(0);
         end
      end else if (pattern == 3) begin
         px_mem[0] = '0; px_mem[1] = '0;
         lib_mem[0][0] = DW'(3); lib_mem[0][1] = '0;
         lib_mem[1][0] = DW'(2); lib_mem[1][1] = '0;
         lib_mem[2][0] = '0;     lib_mem[2][1] = DW'(2);
      end
   endtask

   task automatic run_scan(input int vlen, input int lib, input int corrupt, input bit noise,
                           input longint exp_min_c, input int exp_ref_c);
      longint emn;
      int emr, k, dc, n_rd0, n_st0, n_res0, n_done0, n_rd, wait_n, bad_i;
      bit eer, bad, got;
      model(vlen, lib, corrupt, emn, emr, eer, bad);
      corrupt_ref = corrupt;
      noise_en = noise;
      @(negedge clk);
      n_rd0 = rd_q.size(); n_st0 = st_q.size(); n_res0 = res_cyc_q.size(); n_done0 = done_cnt;
      cfg_vlen = BW'(vlen); cfg_lib_size = LW'(lib); start = 1'b1; k = cyc;
      @(negedge clk);
      chk("busy_after_start", busy, 1);
      start = 1'b1; cfg_vlen = BW'(1); cfg_lib_size = LW'(1);
      @(negedge clk);
      start = 1'b0; cfg_vlen = BW'($urandom); cfg_lib_size = LW'($urandom);
      got = 1'b0; wait_n = 0;
      while (!got && wait_n < 600) begin
         if (done) got = 1'b1;
         else begin @(negedge clk); wait_n++; end
      end
      chk("done_seen", got, 1);
      if (got) begin
         dc = cyc;
         if (bad) chk("done_cycle_badcfg", dc, k + 2);
         else if (res_cyc_q.size() >= n_res0 + lib)
            chk("done_cycle", dc, res_cyc_q[n_res0 + lib - 1] + 1);
         else chk("result_count", res_cyc_q.size() - n_res0, lib);
         chk("error", error, eer);
         chk("min_value", min_value, emn);
         chk("min_ref", min_ref, emr);
         chk("busy_at_done", busy, 0);
         if (exp_min_c >= 0) begin
            chk("table_min_value", min_value, exp_min_c);
            chk("table_min_ref", min_ref, exp_ref_c);
         end
         start = 1'b1; cfg_vlen = BW'(2); cfg_lib_size = LW'(1);
         @(negedge clk);
         start = 1'b0;
         repeat (3) @(negedge clk);
         chk("busy_after_done_start", busy, 0);
         chk("done_pulses", done_cnt - n_done0, 1);
         chk("min_value_held", min_value, emn);
         chk("min_ref_held", min_ref, emr);
         chk("acc_init_zero", acc_init, 0);
      end
      n_rd = rd_q.size() - n_rd0;
      chk("read_count", n_rd, bad ? 0 : vlen * lib);
      if (!bad && n_rd == vlen * lib && st_q.size() - n_st0 >= vlen * lib) begin
         bad_i = -1;
         for (int r = 0; r < lib; r++)
            for (int b = 0; b < vlen; b++) begin
               int i;
               i = r * vlen + b;
               if (bad_i < 0 && (rd_q[n_rd0 + i].r != r || rd_q[n_rd0 + i].b != b ||
                   st_q[n_st0 + i].r != r || st_q[n_st0 + i].a != int'(px_mem[b]) ||
                   st_q[n_st0 + i].bb != int'(lib_mem[r][b]) ||
                   st_q[n_st0 + i].first != (b == 0) || st_q[n_st0 + i].last != (b == vlen - 1)))
                  bad_i = i;
            end
         chk("feed_sequence_first_bad_index", bad_i, -1);
         chk("reads_contiguous", rd_q[n_rd0 + n_rd - 1].c - rd_q[n_rd0].c + 1, n_rd);
      end
   endtask

   typedef struct {int vlen; int lib; int corrupt; int pattern; bit noise; longint exp_min; int exp_ref;} vec_t;
   vec_t tbl[10];

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1);
   end

   initial begin
      tbl[0] = '{4, 3, -1, 2, 1'b0, 0, 0};
      tbl[1] = '{2, 3, -1, 3, 1'b0, 4, 1};
      tbl[2] = '{3, 2, -1, 0, 1'b1, -1, 0};
      tbl[3] = '{0, 3, -1, 0, 1'b0, ONES, 0};
      tbl[4] = '{8, 4,  1, 0, 1'b1, -1, 0};
      tbl[5] = '{9, 2, -1, 0, 1'b0, ONES, 0};
      tbl[6] = '{2, 0, -1, 0, 1'b0, ONES, 0};
      tbl[7] = '{2, 5, -1, 0, 1'b0, ONES, 0};
      tbl[8] = '{1, 1, -1, 1, 1'b1, -1, 0};
      tbl[9] = '{8, 4, -1, 1, 1'b1, -1, 0};

      repeat (3) @(negedge clk);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_error", error, 0);
      chk("rst_min_value", min_value, ONES);
      chk("rst_min_ref", min_ref, 0);
      chk("rst_mem_rd_en", mem_rd_en, 0);
      chk("rst_acc_in_valid", acc_in_valid, 0);
      rst = 1'b0;
      @(negedge clk);

      for (int t = 0; t < 10; t++) begin
         load_data(tbl[t].pattern);
         run_scan(tbl[t].vlen, tbl[t].lib, tbl[t].corrupt, tbl[t].noise,
                  tbl[t].exp_min, tbl[t].exp_ref);
      end

      for (int n = 0; n < 12; n++) begin
         int v, l, c;
         v = int'($urandom_range(1, VL));
         l = int'($urandom_range(1, LS));
         c = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, l - 1)) : -1;
         load_data(int'($urandom_range(0, 1)));
         run_scan(v, l, c, 1'b1, -1, 0);
      end

      // Reset in the middle of a feed, then a clean scan
      load_data(0);
      corrupt_ref = -1;
      @(negedge clk);
      cfg_vlen = BW'(8); cfg_lib_size = LW'(4); start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (5) @(negedge clk);
      chk("midscan_feeding", mem_rd_en, 1);
      rst = 1'b1;
      #1;
      chk("midrst_mem_rd_en", mem_rd_en, 0);
      chk("midrst_acc_in_valid", acc_in_valid, 0);
      chk("midrst_acc_in_last", acc_in_last, 0);
      chk("midrst_acc_init_en", acc_init_en, 0);
      chk("midrst_busy", busy, 0);
      chk("midrst_done", done, 0);
      chk("midrst_min_value", min_value, ONES);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      run_scan(8, 4, -1, 1'b1, -1, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
